// File: rtl/bar_recorder_if.sv
// Note-source handshake and bar-RAM write bus of the bar recorder.
//   note_valid / note_in / note_ready : note event channel (valid/ready)
//   wr_en / wr_bar / wr_row / wr_data : bar RAM write port
// master: the recorder side (accepts notes, drives the write port).
// slave : the environment side (offers notes, receives writes).
interface bar_recorder_if;
  logic       note_valid;
  logic [7:0] note_in;
  logic       note_ready;
  logic       wr_en;
  logic [7:0] wr_bar;
  logic [7:0] wr_row;
  logic [7:0] wr_data;

  modport master (
    input  note_valid, note_in,
    output note_ready, wr_en, wr_bar, wr_row, wr_data
  );

  modport slave (
    output note_valid, note_in,
    input  note_ready, wr_en, wr_bar, wr_row, wr_data
  );
endinterface

// File: rtl/bar_recorder.sv
// bar_recorder: records live notes into one bar, quantized onto the row grid,
// writing exactly one note byte per row (0x00 = rest).
// Ports:
//   main_clk, rst      : clock, synchronous active-high reset
//   tick               : one-cycle song tick strobe
//   arm, rec_bar       : request to record one bar into bar index rec_bar
//   bus (master)       : note valid/ready channel and bar RAM write port
//   row_pos            : current recording row
//   busy, done         : recording in progress / final-write pulse
//   drop_count         : saturating count of invalid or colliding notes
module bar_recorder #(
  parameter int unsigned NUM_ROWS_PER_BAR = 16,
  parameter int unsigned TICKS_PER_ROW    = 8
) (
  input  logic       main_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       arm,
  input  logic [7:0] rec_bar,
  bar_recorder_if.master bus,
  output logic [7:0] row_pos,
  output logic       busy,
  output logic       done,
  output logic [7:0] drop_count
);

  localparam int unsigned TW = (TICKS_PER_ROW > 2) ? $clog2(TICKS_PER_ROW) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_ROW - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(TICKS_PER_ROW / 2);
  localparam logic [7:0]    LAST_ROW  = 8'(NUM_ROWS_PER_BAR - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RECORD
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] tick_cnt, tick_cnt_d;
  logic [7:0]    bar_q, bar_d;
  // A valid note byte is never 0x00 (note field 1..12), so 0x00 marks an empty slot.
  logic [7:0]    cur_slot, cur_slot_d;
  logic [7:0]    nxt_slot, nxt_slot_d;
  logic [7:0]    row_d, drop_d;
  logic          busy_d, done_d;
  logic          wr_en_q, wr_en_d;
  logic [7:0]    wr_bar_q, wr_bar_d;
  logic [7:0]    wr_row_q, wr_row_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic          accept;
  logic          note_ok;
  logic          last_row;
  logic          boundary;
  logic          to_next;

  assign bus.note_ready = (state == RECORD);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_bar     = wr_bar_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_data    = wr_data_q;

  assign accept   = bus.note_valid && (state == RECORD);
  assign note_ok  = (bus.note_in[7:4] >= 4'd1) && (bus.note_in[7:4] <= 4'd12) &&
                    (bus.note_in[3:0] <= 4'd6);
  assign last_row = (row_pos == LAST_ROW);
  assign boundary = tick && (tick_cnt == LAST_TICK);
  // Quantize on the pre-update tick count; the last row has no next row.
  assign to_next  = (tick_cnt >= HALF_TICK) && !last_row;

  always_ff @(posedge main_clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bar_q      <= '0;
      cur_slot   <= '0;
      nxt_slot   <= '0;
      row_pos    <= '0;
      drop_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_bar_q   <= '0;
      wr_row_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      state      <= state_d;
      tick_cnt   <= tick_cnt_d;
      bar_q      <= bar_d;
      cur_slot   <= cur_slot_d;
      nxt_slot   <= nxt_slot_d;
      row_pos    <= row_d;
      drop_count <= drop_d;
      busy       <= busy_d;
      done       <= done_d;
      wr_en_q    <= wr_en_d;
      wr_bar_q   <= wr_bar_d;
      wr_row_q   <= wr_row_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bar_d      = bar_q;
    cur_slot_d = cur_slot;
    nxt_slot_d = nxt_slot;
    row_d      = row_pos;
    drop_d     = drop_count;
    busy_d     = busy;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_bar_d   = wr_bar_q;
    wr_row_d   = wr_row_q;
    wr_data_d  = wr_data_q;

    // busy stays high through the done cycle and falls on the next one.
    if (done) begin
      busy_d = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (arm) begin
          bar_d   = rec_bar;
          drop_d  = '0;
          busy_d  = 1'b1;
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (tick) begin
          tick_cnt_d = '0;
          row_d      = '0;
          cur_slot_d = '0;
          nxt_slot_d = '0;
          state_d    = RECORD;
        end
      end

      RECORD: begin
        if (accept) begin
          if (!note_ok) begin
            if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
          end else if (to_next) begin
            if (nxt_slot_d != 8'h00) begin
              if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
            end else begin
              nxt_slot_d = bus.note_in;
            end
          end else begin
            if (cur_slot_d != 8'h00) begin
              if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
            end else begin
              cur_slot_d = bus.note_in;
            end
          end
        end

        if (tick) begin
          if (boundary) begin
            // Slots already include this cycle's note, so a boundary-tick note
            // lands in the next row, or in the final write on the last row.
            tick_cnt_d = '0;
            wr_en_d    = 1'b1;
            wr_bar_d   = bar_q;
            wr_row_d   = row_pos;
            wr_data_d  = cur_slot_d;
            if (last_row) begin
              done_d     = 1'b1;
              row_d      = '0;
              cur_slot_d = '0;
              nxt_slot_d = '0;
              state_d    = IDLE;
            end else begin
              row_d      = row_pos + 8'd1;
              cur_slot_d = nxt_slot_d;
              nxt_slot_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt + TW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bar_recorder.sv
// Directed bench for bar_recorder: records several bars with hand-placed
// notes and checks every bar RAM write, handshake, drop counting and reset.
module tb_bar_recorder;

  logic       main_clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       arm;
  logic [7:0] rec_bar;
  logic [7:0] row_pos;
  logic       busy;
  logic       done;
  logic [7:0] drop_count;

  bar_recorder_if bus();

  bar_recorder #(
    .NUM_ROWS_PER_BAR(16),
    .TICKS_PER_ROW   (8)
  ) dut (
    .main_clk  (main_clk),
    .rst       (rst),
    .tick      (tick),
    .arm       (arm),
    .rec_bar   (rec_bar),
    .bus       (bus),
    .row_pos   (row_pos),
    .busy      (busy),
    .done      (done),
    .drop_count(drop_count)
  );

  always #5 main_clk = ~main_clk;

  int checks = 0;
  int errors = 0;

  // Write log filled at the falling edge.
  logic [7:0] log_bar  [128];
  logic [7:0] log_row  [128];
  logic [7:0] log_data [128];
  logic       log_done [128];
  int         wr_n = 0;

  always @(negedge main_clk) begin
    if (bus.wr_en === 1'b1 && wr_n < 128) begin
      log_bar[wr_n]  = bus.wr_bar;
      log_row[wr_n]  = bus.wr_row;
      log_data[wr_n] = bus.wr_data;
      log_done[wr_n] = done;
      wr_n = wr_n + 1;
    end
  end

  // Note schedule for one bar: position g = row*8 + tick_cnt; on_tick means
  // the note is offered in the same cycle as the tick leaving position g.
  int         sched_g       [8];
  logic [7:0] sched_note    [8];
  bit         sched_on_tick [8];
  int         n_sched;
  int         glitch_g;
  logic [7:0] exp_data      [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic send_note(input logic [7:0] n);
    bus.note_valid = 1'b1;
    bus.note_in    = n;
    check("note_ready", 32'(bus.note_ready), 32'd1);
    step();
    bus.note_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_note_ready"}, 32'(bus.note_ready), 32'd0);
    check({tag, "_wr_en"},      32'(bus.wr_en),      32'd0);
    check({tag, "_done"},       32'(done),           32'd0);
    check({tag, "_busy"},       32'(busy),           32'd0);
    check({tag, "_wr_bar"},     32'(bus.wr_bar),     32'd0);
    check({tag, "_wr_row"},     32'(bus.wr_row),     32'd0);
    check({tag, "_wr_data"},    32'(bus.wr_data),    32'd0);
    check({tag, "_row_pos"},    32'(row_pos),        32'd0);
    check({tag, "_drop"},       32'(drop_count),     32'd0);
  endtask

  task automatic run_bar(input logic [7:0] bar, input int stop_g);
    arm     = 1'b1;
    rec_bar = bar;
    step();
    arm     = 1'b0;
    rec_bar = 8'h00;
    check("busy_after_arm", 32'(busy), 32'd1);
    check("drop_cleared", 32'(drop_count), 32'd0);
    // A note offered in SYNC must not be taken.
    bus.note_valid = 1'b1;
    bus.note_in    = 8'h99;
    check("ready_in_sync", 32'(bus.note_ready), 32'd0);
    step();
    bus.note_valid = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("row_pos_sync", 32'(row_pos), 32'd0);
    for (int g = 0; g < stop_g; g++) begin
      for (int i = 0; i < n_sched; i++)
        if (sched_g[i] == g && !sched_on_tick[i]) send_note(sched_note[i]);
      if (g == glitch_g) begin
        arm     = 1'b1;
        rec_bar = 8'hEE;
        step();
        arm     = 1'b0;
        rec_bar = 8'h00;
      end
      tick = 1'b1;
      for (int i = 0; i < n_sched; i++)
        if (sched_g[i] == g && sched_on_tick[i]) begin
          bus.note_valid = 1'b1;
          bus.note_in    = sched_note[i];
        end
      step();
      tick           = 1'b0;
      bus.note_valid = 1'b0;
      if (g == 127) begin
        check("done_final", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        check("wr_en_final", 32'(bus.wr_en), 32'd1);
      end
      step();
      if (g % 8 == 7 && g != 127) check("row_pos", 32'(row_pos), 32'((g + 1) / 8));
    end
    if (stop_g == 128) begin
      check("busy_end", 32'(busy), 32'd0);
      check("done_end", 32'(done), 32'd0);
    end
  endtask

  task automatic verify_bar(input logic [7:0] bar, input int base);
    check("wr_count", 32'(wr_n - base), 32'd16);
    for (int r = 0; r < 16; r++) begin
      check("wr_bar",  32'(log_bar[base + r]),  32'(bar));
      check("wr_row",  32'(log_row[base + r]),  32'(r));
      check("wr_data", 32'(log_data[base + r]), 32'(exp_data[r]));
      check("wr_done", 32'(log_done[base + r]), (r == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic clear_plan();
    n_sched  = 0;
    glitch_g = -1;
    for (int r = 0; r < 16; r++) exp_data[r] = 8'h00;
  endtask

  task automatic add_note(input int g, input logic [7:0] n, input bit on_tick);
    sched_g[n_sched]       = g;
    sched_note[n_sched]    = n;
    sched_on_tick[n_sched] = on_tick;
    n_sched++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst            = 1'b1;
    tick           = 1'b0;
    arm            = 1'b0;
    rec_bar        = 8'h00;
    bus.note_valid = 1'b0;
    bus.note_in    = 8'h00;
    step();
    step();
    rst = 1'b0;
    check_reset_values("reset");

    // Ticks and notes while IDLE are ignored.
    tick           = 1'b1;
    bus.note_valid = 1'b1;
    bus.note_in    = 8'h54;
    check("ready_in_idle", 32'(bus.note_ready), 32'd0);
    step();
    step();
    tick           = 1'b0;
    bus.note_valid = 1'b0;
    check("idle_no_write", 32'(wr_n), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_drop", 32'(drop_count), 32'd0);

    // Basic record.
    clear_plan();
    add_note(1, 8'h54, 1'b0);
    exp_data[0] = 8'h54;
    base = wr_n;
    run_bar(8'd3, 128);
    verify_bar(8'd3, base);
    check("drop_basic", 32'(drop_count), 32'd0);

    // Invalid notes, late quantize, collision, boundary-tick note, last row,
    // and an arm during RECORD that must be ignored.
    clear_plan();
    add_note(9,   8'hD4, 1'b0);
    add_note(10,  8'h07, 1'b0);
    add_note(21,  8'hA3, 1'b0);
    add_note(32,  8'h14, 1'b0);
    add_note(34,  8'h24, 1'b0);
    add_note(39,  8'h61, 1'b1);
    add_note(126, 8'h34, 1'b0);
    glitch_g     = 50;
    exp_data[3]  = 8'hA3;
    exp_data[4]  = 8'h14;
    exp_data[5]  = 8'h61;
    exp_data[15] = 8'h34;
    base = wr_n;
    run_bar(8'd7, 128);
    verify_bar(8'd7, base);
    check("drop_mixed", 32'(drop_count), 32'd3);

    // Reset right after the row 5 write.
    clear_plan();
    add_note(3, 8'h45, 1'b0);
    base = wr_n;
    run_bar(8'd9, 48);
    check("partial_count", 32'(wr_n - base), 32'd6);
    check("partial_row0", 32'(log_data[base]), 32'h45);
    check("partial_row5", 32'(log_row[base + 5]), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("midrst");
    base = wr_n;
    for (int k = 0; k < 20; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    check("no_write_after_rst", 32'(wr_n - base), 32'd0);

    // Fresh record after reset; boundary-tick note in the last row stays there.
    clear_plan();
    add_note(0,   8'h11, 1'b0);
    add_note(127, 8'hC6, 1'b1);
    exp_data[0]  = 8'h11;
    exp_data[15] = 8'hC6;
    base = wr_n;
    run_bar(8'h2A, 128);
    verify_bar(8'h2A, base);
    check("drop_last", 32'(drop_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
